ip1_testx_shift_reg: RTL and testbench

Configuration shift-register stage that sits directly upstream of the IP1 test state machines. It holds a 768-bit software-written pattern and parallel-loads it into a working shift register on `shift_reg_load`. It shifts the register right one bit per `shift_reg_shift` pulse, presenting bit 0 and a shift count to the state machine. It also captures the ASIC's serial readback and counts bit mismatches against the written pattern.

---
 rtl/ip1_testx_pkg.sv | 18 +
 rtl/ip1_testx_cfg_buf.sv | 30 +++
 rtl/ip1_testx_shift_reg.sv | 108 ++++++++++
 tb/tb_ip1_testx_shift_reg.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip1_testx_pkg.sv
// Shared constants and helpers for the IP1 test configuration shift-register stage.
package ip1_testx_pkg;

  localparam int SR_WIDTH = 768;
  localparam int WORD_W   = 32;
  localparam int NWORDS   = SR_WIDTH / WORD_W;
  localparam int CNT_W    = 13;
  localparam int IDX_W    = $clog2(SR_WIDTH);

  // A zero or oversized bit count means "use the whole register".
  function automatic logic [CNT_W-1:0] clamp_nbits(input logic [CNT_W-1:0] nbits);
    if (nbits == '0 || nbits > CNT_W'(SR_WIDTH)) begin
      return CNT_W'(SR_WIDTH);
    end
    return nbits;
  endfunction

endpackage

// File: rtl/ip1_testx_cfg_buf.sv
// Software-written pattern buffer: NWORDS x WORD_W words presented as one flat vector.
module ip1_testx_cfg_buf
  import ip1_testx_pkg::*;
(
  input  logic                clk,
  input  logic                reset_not,
  input  logic                i_wr_en,
  input  logic [4:0]          i_wr_addr,
  input  logic [WORD_W-1:0]   i_wr_data,
  output logic [SR_WIDTH-1:0] o_buf
);

  logic [WORD_W-1:0] r_mem [NWORDS];

  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) begin
      for (int k = 0; k < NWORDS; k++) begin
        r_mem[k] <= '0;
      end
    end else if (i_wr_en && (i_wr_addr < 5'(NWORDS))) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Word k holds pattern bits [WORD_W*k +: WORD_W].
  for (genvar g = 0; g < NWORDS; g++) begin : g_flat
    assign o_buf[g*WORD_W +: WORD_W] = r_mem[g];
  end

endmodule

// File: rtl/ip1_testx_shift_reg.sv
// Working shift register, shift/capture counters and readback mismatch counting
// for the IP1 test state machines.
module ip1_testx_shift_reg
  import ip1_testx_pkg::*;
(
  input  logic              clk,
  input  logic              reset_not,
  input  logic              enable,
  input  logic              cfg_wr_en,
  input  logic [4:0]        cfg_wr_addr,
  input  logic [WORD_W-1:0] cfg_wr_data,
  input  logic [CNT_W-1:0]  cfg_nbits,
  input  logic [4:0]        rd_addr,
  output logic [WORD_W-1:0] rd_data,
  input  logic              shift_reg_load,
  input  logic              shift_reg_shift,
  output logic              shift_reg_bit0,
  output logic [CNT_W-1:0]  shift_reg_shift_cnt,
  output logic [CNT_W-1:0]  shift_reg_shift_cnt_max,
  input  logic              scan_out,
  input  logic              scan_capture,
  output logic [CNT_W-1:0]  capture_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt
);

  // Strobes (load/shift/capture/wr_en) are single-cycle samples with no
  // back-pressure: each one is acted on at the edge that sees it high, or dropped.
  logic [SR_WIDTH-1:0] w_buf;
  logic [SR_WIDTH-1:0] r_sr;
  logic [SR_WIDTH-1:0] r_cap;
  logic [CNT_W-1:0]    r_shift_cnt;
  logic [CNT_W-1:0]    r_cnt_max;
  logic [CNT_W-1:0]    r_cap_cnt;
  logic [CNT_W-1:0]    r_mis_cnt;
  logic [WORD_W-1:0]   r_rd_data;
  logic [WORD_W-1:0]   w_cap_words [NWORDS];
  logic [IDX_W-1:0]    w_cap_idx;
  logic                w_shift_ok;
  logic                w_cap_ok;

  ip1_testx_cfg_buf u_cfg_buf (
    .clk       (clk),
    .reset_not (reset_not),
    .i_wr_en   (cfg_wr_en && enable),
    .i_wr_addr (cfg_wr_addr),
    .i_wr_data (cfg_wr_data),
    .o_buf     (w_buf)
  );

  for (genvar g = 0; g < NWORDS; g++) begin : g_cap_words
    assign w_cap_words[g] = r_cap[g*WORD_W +: WORD_W];
  end

  assign w_shift_ok = shift_reg_shift && (r_shift_cnt != r_cnt_max);
  assign w_cap_ok   = scan_capture && (r_cap_cnt < r_cnt_max);
  // Only used while r_cap_cnt < r_cnt_max <= SR_WIDTH, so truncation is safe.
  assign w_cap_idx  = r_cap_cnt[IDX_W-1:0];

  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) begin
      r_sr        <= '0;
      r_cap       <= '0;
      r_shift_cnt <= '0;
      r_cnt_max   <= '0;
      r_cap_cnt   <= '0;
      r_mis_cnt   <= '0;
      r_rd_data   <= '0;
    end else if (!enable) begin
      r_sr        <= '0;
      r_cap       <= '0;
      r_shift_cnt <= '0;
      r_cap_cnt   <= '0;
      r_mis_cnt   <= '0;
      r_rd_data   <= '0;
    end else begin
      r_cnt_max <= clamp_nbits(cfg_nbits);
      r_rd_data <= (rd_addr < 5'(NWORDS)) ? w_cap_words[rd_addr] : '0;
      if (shift_reg_load) begin
        // Load wins over shift and capture; a same-cycle buffer write is not seen.
        r_sr        <= w_buf;
        r_cap       <= '0;
        r_shift_cnt <= '0;
        r_cap_cnt   <= '0;
        r_mis_cnt   <= '0;
      end else begin
        if (w_shift_ok) begin
          r_sr        <= {1'b0, r_sr[SR_WIDTH-1:1]};
          r_shift_cnt <= r_shift_cnt + 1'b1;
        end
        if (w_cap_ok) begin
          r_cap[w_cap_idx] <= scan_out;
          r_cap_cnt        <= r_cap_cnt + 1'b1;
          if (scan_out != w_buf[w_cap_idx]) begin
            r_mis_cnt <= r_mis_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign shift_reg_bit0          = r_sr[0];
  assign shift_reg_shift_cnt     = r_shift_cnt;
  assign shift_reg_shift_cnt_max = r_cnt_max;
  assign capture_cnt             = r_cap_cnt;
  assign mismatch_cnt            = r_mis_cnt;
  assign rd_data                 = r_rd_data;

endmodule

// File: tb/tb_ip1_testx_shift_reg.sv
// Bench for ip1_testx_shift_reg: pattern load/shift, saturation, capture/mismatch,
// clamping, enable and asynchronous reset behaviour.
module tb_ip1_testx_shift_reg;
  import ip1_testx_pkg::*;

  logic              clk = 1'b0;
  logic              reset_not = 1'b0;
  logic              enable = 1'b0;
  logic              cfg_wr_en = 1'b0;
  logic [4:0]        cfg_wr_addr = '0;
  logic [WORD_W-1:0] cfg_wr_data = '0;
  logic [CNT_W-1:0]  cfg_nbits = 13'd768;
  logic [4:0]        rd_addr = '0;
  logic [WORD_W-1:0] rd_data;
  logic              shift_reg_load = 1'b0;
  logic              shift_reg_shift = 1'b0;
  logic              shift_reg_bit0;
  logic [CNT_W-1:0]  shift_reg_shift_cnt;
  logic [CNT_W-1:0]  shift_reg_shift_cnt_max;
  logic              scan_out = 1'b0;
  logic              scan_capture = 1'b0;
  logic [CNT_W-1:0]  capture_cnt;
  logic [CNT_W-1:0]  mismatch_cnt;

  logic [SR_WIDTH-1:0] pat;
  logic [31:0]         exp_q[$];
  logic [31:0]         e;
  int                  checks = 0;
  int                  errors = 0;

  ip1_testx_shift_reg dut (
    .clk                     (clk),
    .reset_not               (reset_not),
    .enable                  (enable),
    .cfg_wr_en               (cfg_wr_en),
    .cfg_wr_addr             (cfg_wr_addr),
    .cfg_wr_data             (cfg_wr_data),
    .cfg_nbits               (cfg_nbits),
    .rd_addr                 (rd_addr),
    .rd_data                 (rd_data),
    .shift_reg_load          (shift_reg_load),
    .shift_reg_shift         (shift_reg_shift),
    .shift_reg_bit0          (shift_reg_bit0),
    .shift_reg_shift_cnt     (shift_reg_shift_cnt),
    .shift_reg_shift_cnt_max (shift_reg_shift_cnt_max),
    .scan_out                (scan_out),
    .scan_capture            (scan_capture),
    .capture_cnt             (capture_cnt),
    .mismatch_cnt            (mismatch_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cfg_wr_addr = a;
    cfg_wr_data = d;
    cfg_wr_en   = 1'b1;
    tick();
    cfg_wr_en   = 1'b0;
  endtask

  task automatic write_pattern();
    for (int k = 0; k < NWORDS; k++) wr(5'(k), pat[k*32 +: 32]);
  endtask

  task automatic set_nbits(input logic [CNT_W-1:0] n);
    cfg_nbits = n;
    tick();
  endtask

  task automatic load();
    shift_reg_load = 1'b1;
    tick();
    shift_reg_load = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_not = 1'b0;
    tick(3);
    checks++;
    if ({shift_reg_bit0, shift_reg_shift_cnt, shift_reg_shift_cnt_max, capture_cnt, mismatch_cnt, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_state got bit0=%b cnt=%0d max=%0d cap=%0d mis=%0d rd=%h exp all 0",
               shift_reg_bit0, shift_reg_shift_cnt, shift_reg_shift_cnt_max, capture_cnt, mismatch_cnt, rd_data);
    end
    reset_not = 1'b1;
    enable    = 1'b1;
    tick();
  endtask

  task automatic test_full_shift();
    set_nbits(13'd768);
    load();
    checks++;
    if (shift_reg_bit0 !== pat[0]) begin
      errors++;
      $display("FAIL load_bit0 got %b exp %b", shift_reg_bit0, pat[0]);
    end
    for (int j = 1; j <= SR_WIDTH + 3; j++) begin
      exp_q.push_back((j < SR_WIDTH) ? 32'(pat[j]) : 32'd0);
      shift_reg_shift = 1'b1;
      tick();
      shift_reg_shift = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (32'(shift_reg_bit0) !== e) begin
        errors++;
        $display("FAIL shift_bit0[%0d] got %0d exp %0d", j, shift_reg_bit0, e);
      end
      tick(3);
    end
    checks++;
    if (shift_reg_shift_cnt !== 13'd768) begin
      errors++;
      $display("FAIL full_shift_cnt got %0d exp 768", shift_reg_shift_cnt);
    end
  endtask

  task automatic test_saturate();
    set_nbits(13'd5);
    checks++;
    if (shift_reg_shift_cnt_max !== 13'd5) begin
      errors++;
      $display("FAIL max_5 got %0d exp 5", shift_reg_shift_cnt_max);
    end
    load();
    for (int j = 1; j <= 7; j++) begin
      exp_q.push_back((j < 5) ? j : 5);
      shift_reg_shift = 1'b1;
      tick();
      shift_reg_shift = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (32'(shift_reg_shift_cnt) !== e) begin
        errors++;
        $display("FAIL sat_cnt[%0d] got %0d exp %0d", j, shift_reg_shift_cnt, e);
      end
    end
    checks++;
    if (shift_reg_bit0 !== pat[5]) begin
      errors++;
      $display("FAIL sat_bit0 got %b exp %b", shift_reg_bit0, pat[5]);
    end
  endtask

  task automatic test_load_and_shift();
    set_nbits(13'd768);
    load();
    shift_reg_shift = 1'b1;
    tick(10);
    checks++;
    if (shift_reg_shift_cnt !== 13'd10) begin
      errors++;
      $display("FAIL pre_ls_cnt got %0d exp 10", shift_reg_shift_cnt);
    end
    shift_reg_load = 1'b1;
    tick();
    shift_reg_load  = 1'b0;
    shift_reg_shift = 1'b0;
    checks++;
    if (shift_reg_shift_cnt !== 13'd0 || shift_reg_bit0 !== pat[0]) begin
      errors++;
      $display("FAIL load_shift got cnt=%0d bit0=%b exp cnt=0 bit0=%b", shift_reg_shift_cnt, shift_reg_bit0, pat[0]);
    end
  endtask

  task automatic test_forwarding();
    cfg_wr_addr    = 5'd0;
    cfg_wr_data    = 32'hFFFF_FFFF;
    cfg_wr_en      = 1'b1;
    shift_reg_load = 1'b1;
    tick();
    cfg_wr_en      = 1'b0;
    shift_reg_load = 1'b0;
    checks++;
    if (shift_reg_bit0 !== pat[0]) begin
      errors++;
      $display("FAIL fwd_old_word got %b exp %b", shift_reg_bit0, pat[0]);
    end
    load();
    checks++;
    if (shift_reg_bit0 !== 1'b1) begin
      errors++;
      $display("FAIL fwd_new_word got %b exp 1", shift_reg_bit0);
    end
    wr(5'd0, pat[31:0]);
  endtask

  task automatic test_capture();
    set_nbits(13'd768);
    load();
    for (int i = 0; i < SR_WIDTH; i++) begin
      scan_out        = shift_reg_bit0 ^ (i == 100);
      scan_capture    = 1'b1;
      shift_reg_shift = 1'b1;
      tick();
    end
    shift_reg_shift = 1'b0;
    scan_out        = 1'b1;
    tick(2);
    scan_capture    = 1'b0;
    checks++;
    if (capture_cnt !== 13'd768 || mismatch_cnt !== 13'd1) begin
      errors++;
      $display("FAIL capture_counts got cap=%0d mis=%0d exp cap=768 mis=1", capture_cnt, mismatch_cnt);
    end
    exp_q.push_back(pat[96 +: 32] ^ 32'h10);
    exp_q.push_back(pat[31:0]);
    exp_q.push_back(pat[767:736]);
    exp_q.push_back(32'd0);
    for (int k = 0; k < 4; k++) begin
      rd_addr = (k == 0) ? 5'd3 : (k == 1) ? 5'd0 : (k == 2) ? 5'd23 : 5'd24;
      tick();
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e) begin
        errors++;
        $display("FAIL rd_data[%0d] got %h exp %h", rd_addr, rd_data, e);
      end
    end
  endtask

  task automatic test_clamp_and_bad_addr();
    logic [CNT_W-1:0] nb [5] = '{13'd0, 13'd2000, 13'd768, 13'd1, 13'd769};
    logic [CNT_W-1:0] ex [5] = '{13'd768, 13'd768, 13'd768, 13'd1, 13'd768};
    for (int k = 0; k < 5; k++) begin
      set_nbits(nb[k]);
      checks++;
      if (shift_reg_shift_cnt_max !== ex[k]) begin
        errors++;
        $display("FAIL clamp[%0d] got %0d exp %0d", nb[k], shift_reg_shift_cnt_max, ex[k]);
      end
    end
    wr(5'd24, 32'hFFFF_FFFF);
    wr(5'd31, 32'hFFFF_FFFF);
    load();
    for (int j = 0; j < SR_WIDTH; j++) begin
      exp_q.push_back(32'(pat[j]));
      e = exp_q.pop_front();
      checks++;
      if (32'(shift_reg_bit0) !== e) begin
        errors++;
        $display("FAIL badaddr_bit0[%0d] got %0d exp %0d", j, shift_reg_bit0, e);
      end
      shift_reg_shift = 1'b1;
      tick();
      shift_reg_shift = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    set_nbits(13'd768);
    load();
    shift_reg_shift = 1'b1;
    tick(300);
    shift_reg_shift = 1'b0;
    checks++;
    if (shift_reg_shift_cnt !== 13'd300 || shift_reg_bit0 !== pat[300]) begin
      errors++;
      $display("FAIL pre_reset got cnt=%0d bit0=%b exp cnt=300 bit0=%b", shift_reg_shift_cnt, shift_reg_bit0, pat[300]);
    end
    #2 reset_not = 1'b0;
    #1;
    checks++;
    if ({shift_reg_bit0, shift_reg_shift_cnt, shift_reg_shift_cnt_max, capture_cnt, mismatch_cnt, rd_data} !== '0) begin
      errors++;
      $display("FAIL async_reset got bit0=%b cnt=%0d max=%0d cap=%0d mis=%0d rd=%h exp all 0",
               shift_reg_bit0, shift_reg_shift_cnt, shift_reg_shift_cnt_max, capture_cnt, mismatch_cnt, rd_data);
    end
    tick(2);
    reset_not = 1'b1;
    tick();
    // Buffer was cleared: capturing ones must mismatch on every bit.
    load();
    scan_out     = 1'b1;
    scan_capture = 1'b1;
    tick(32);
    scan_capture = 1'b0;
    checks++;
    if (mismatch_cnt !== 13'd32 || capture_cnt !== 13'd32) begin
      errors++;
      $display("FAIL buf_cleared got mis=%0d cap=%0d exp 32/32", mismatch_cnt, capture_cnt);
    end
    write_pattern();
  endtask

  task automatic test_enable();
    set_nbits(13'd768);
    load();
    scan_out        = 1'b0;
    scan_capture    = 1'b1;
    shift_reg_shift = 1'b1;
    tick(20);
    scan_capture    = 1'b0;
    shift_reg_shift = 1'b0;
    enable          = 1'b0;
    cfg_nbits       = 13'd3;
    wr(5'd0, 32'hFFFF_FFFF);
    tick();
    checks++;
    if ({shift_reg_bit0, shift_reg_shift_cnt, capture_cnt, mismatch_cnt} !== '0 || shift_reg_shift_cnt_max !== 13'd768) begin
      errors++;
      $display("FAIL disable got bit0=%b cnt=%0d cap=%0d mis=%0d max=%0d exp 0/0/0/0/768",
               shift_reg_bit0, shift_reg_shift_cnt, capture_cnt, mismatch_cnt, shift_reg_shift_cnt_max);
    end
    cfg_nbits = 13'd768;
    enable    = 1'b1;
    tick();
    load();
    for (int j = 0; j < SR_WIDTH; j++) begin
      exp_q.push_back(32'(pat[j]));
      e = exp_q.pop_front();
      checks++;
      if (32'(shift_reg_bit0) !== e) begin
        errors++;
        $display("FAIL reload_bit0[%0d] got %0d exp %0d", j, shift_reg_bit0, e);
      end
      shift_reg_shift = 1'b1;
      tick();
      shift_reg_shift = 1'b0;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int k = 0; k < NWORDS; k++) pat[k*32 +: 32] = 32'hA5A5_0000 + 32'(k);
    test_reset();
    write_pattern();
    test_full_shift();
    test_saturate();
    test_load_and_shift();
    test_forwarding();
    test_capture();
    test_clamp_and_bad_addr();
    test_async_reset();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
